gate_resp_checker: RTL and testbench
====================================

// Module: gate_resp_checker
// PURPOSE
//   Synthesizable response-side companion to our gate stimulus benches: drives
//   an exhaustive input-vector sequence into a combinational gate-under-test
//   (GUT) and samples the GUT output. Compares each sample against a
//   parameterised truth table, then reports pass/fail, error count and the
//   first failing vector. Sits beside any N-input gate in the assignment tree.
//   Default configuration checks a 2-input AND.
// PARAMETERS
//   N_IN    2        GUT input count; vectors 0 .. 2**N_IN-1
//   TRUTH   4'b1000  expected y; bit k = y for vector k (width 2**N_IN)
//   SETTLE  2        cycles vec is held before sampling; legal range >= 1
//   ERR_W   8        err_cnt width
// PORTS
//   clk             in   1      single clock, all logic on rising edge
//   rst_n           in   1      synchronous reset, active-low
//   start           in   1      request a run; sampled only in IDLE or DONE
//   dut_y           in   1      GUT output
//   vec             out  N_IN   GUT inputs; vec[0]=a, vec[1]=b, ...
//   busy            out  1      high in WAIT/SAMPLE
//   done            out  1      sticky; high in DONE
//   pass            out  1      done && err_cnt==0
//   err_cnt         out  ERR_W  mismatch count, saturates at all-ones
//   fail_valid      out  1      first_fail holds a captured vector
//   first_fail      out  N_IN   first vector whose sample mismatched
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge, incl. mid-run): state=IDLE; vec, busy, done,
//     pass, err_cnt, fail_valid, first_fail all 0. Reset has priority over all.
//   States: IDLE, WAIT, SAMPLE, DONE (registered FSM, registered outputs).
//   IDLE  : start=1 -> WAIT; idx=0, vec=0, wcnt=SETTLE-1.
//           err_cnt, fail_valid, first_fail cleared.
//   WAIT  : wcnt>0 -> wcnt--; wcnt==0 -> SAMPLE. vec held stable.
//   SAMPLE: mismatch when dut_y != TRUTH[idx].
//           On mismatch, err_cnt++ (hold at max).
//           On mismatch with fail_valid=0: first_fail=idx, fail_valid=1.
//           idx==2**N_IN-1 -> DONE.
//           Else idx++, vec=idx+1, wcnt=SETTLE-1, -> WAIT.
//   DONE  : done=1; results held until start=1.
//           start=1 behaves as in IDLE (done drops next cycle).
//   start while busy: ignored, no effect on run.
//   Timing: start seen in cycle 0. Vector k is applied from cycle
//     1+k*(SETTLE+1) and sampled in cycle (k+1)*(SETTLE+1).
//   done first high in cycle 2**N_IN*(SETTLE+1)+1 (13 for defaults).
//   idx counter is N_IN+1 bits wide; no wrap of vec during a run.
//   vec returns to 0 only on reset or a new start; it holds last vector in DONE.
//   dut_y is sampled only in SAMPLE; its value in other states is don't-care.
// TESTING
//   1 Correct AND GUT, defaults: start pulse cycle 0 -> vec 0,1,2,3.
//     done=1 at cycle 13, pass=1, err_cnt=0, fail_valid=0.
//   2 GUT stuck-at-1: dut_y=1 always -> err_cnt=3, first_fail=0,
//     fail_valid=1, pass=0.
//   3 Reset mid-run: rst_n=0 at cycle 5 -> next cycle all outputs 0, IDLE.
//     New start -> full clean run.
//   4 start pulsed at cycles 3 and 7 while busy -> ignored.
//     done still at cycle 13.
//   5 Restart from DONE: second start after a failing run -> err_cnt and
//     fail_valid cleared; correct GUT gives pass=1.
//   6 SETTLE=1, N_IN=3, TRUTH=8'h80 (AND3): done at cycle 17.
//     Force mismatch on vector 5 only -> err_cnt=1, first_fail=5.

Source files
------------

// File: rtl/gate_resp_checker.sv
// Exhaustive response checker for an N_IN-input combinational gate: walks every
// input vector, samples the gate output after a settle time and scores it against TRUTH.
module gate_resp_checker #(
  parameter int                  N_IN   = 2,
  parameter logic [2**N_IN-1:0]  TRUTH  = 4'b1000,
  parameter int                  SETTLE = 2,
  parameter int                  ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dut_y,
  output logic [N_IN-1:0]  vec,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [N_IN-1:0]  first_fail
);

  localparam int            NV     = 2**N_IN;
  localparam int            WCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN:0] LAST   = (N_IN+1)'(NV - 1);

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

  state_t             state, state_n;
  logic [N_IN:0]      idx, idx_n;
  logic [WCNT_W-1:0]  wcnt, wcnt_n;
  logic [N_IN-1:0]    vec_n;
  logic [ERR_W-1:0]   err_cnt_n;
  logic               fail_valid_n;
  logic [N_IN-1:0]    first_fail_n;
  logic               mismatch;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (&c) ? c : c + ERR_W'(1);
  endfunction

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    wcnt_n       = wcnt;
    vec_n        = vec;
    err_cnt_n    = err_cnt;
    fail_valid_n = fail_valid;
    first_fail_n = first_fail;
    mismatch     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n      = WAIT;
          idx_n        = '0;
          vec_n        = '0;
          wcnt_n       = WCNT_W'(SETTLE - 1);
          err_cnt_n    = '0;
          fail_valid_n = 1'b0;
          first_fail_n = '0;
        end
      end
      WAIT: begin
        if (wcnt != '0) wcnt_n = wcnt - WCNT_W'(1);
        else            state_n = SAMPLE;
      end
      SAMPLE: begin
        mismatch = (dut_y != TRUTH[idx[N_IN-1:0]]);
        if (mismatch) begin
          err_cnt_n = sat_inc(err_cnt);
          // Only the earliest failing vector is kept.
          if (!fail_valid) begin
            first_fail_n = idx[N_IN-1:0];
            fail_valid_n = 1'b1;
          end
        end
        if (idx == LAST) begin
          state_n = DONE;
        end else begin
          idx_n   = idx + (N_IN+1)'(1);
          vec_n   = idx_n[N_IN-1:0];
          wcnt_n  = WCNT_W'(SETTLE - 1);
          state_n = WAIT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      wcnt       <= '0;
      vec        <= '0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      wcnt       <= wcnt_n;
      vec        <= vec_n;
      err_cnt    <= err_cnt_n;
      fail_valid <= fail_valid_n;
      first_fail <= first_fail_n;
    end
  end

  assign busy = (state == WAIT) || (state == SAMPLE);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_gate_resp_checker.sv
// Bench for gate_resp_checker: three configurations (AND2, AND3 fast settle,
// AND2 with a 2-bit error counter) driven by a bench-side gate response table.
module tb_gate_resp_checker;

  localparam int MAXC = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [7:0] resp = 8'h00;

  logic [1:0] vec_a, ff_a;
  logic [2:0] vec_b, ff_b;
  logic [1:0] vec_c, ff_c;
  logic [7:0] err_a, err_b;
  logic [1:0] err_c;
  logic busy_a, done_a, pass_a, fv_a, y_a;
  logic busy_b, done_b, pass_b, fv_b, y_b;
  logic busy_c, done_c, pass_c, fv_c, y_c;

  assign y_a = resp[vec_a];
  assign y_b = resp[vec_b];
  assign y_c = resp[vec_c];

  always #5 clk = ~clk;

  gate_resp_checker u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .dut_y(y_a), .vec(vec_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .fail_valid(fv_a), .first_fail(ff_a));

  gate_resp_checker #(.N_IN(3), .TRUTH(8'h80), .SETTLE(1), .ERR_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dut_y(y_b), .vec(vec_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
    .fail_valid(fv_b), .first_fail(ff_b));

  gate_resp_checker #(.N_IN(2), .TRUTH(4'b1000), .SETTLE(1), .ERR_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .dut_y(y_c), .vec(vec_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_cnt(err_c),
    .fail_valid(fv_c), .first_fail(ff_c));

  int n_checks = 0;
  int n_fail   = 0;

  int obs_vec  [0:MAXC];
  int obs_busy [0:MAXC];
  int obs_done [0:MAXC];
  int obs_pass, obs_err, obs_fv, obs_ff;

  function automatic int n_of(input int sel);
    return (sel == 1) ? 3 : 2;
  endfunction
  function automatic int s_of(input int sel);
    return (sel == 0) ? 2 : 1;
  endfunction
  function automatic int errmax_of(input int sel);
    return (sel == 2) ? 3 : 255;
  endfunction

  // Reference gate is an AND: output 1 only for the all-ones vector.
  function automatic int model_errs(input int sel, input logic [7:0] r);
    int e = 0;
    for (int v = 0; v < (1 << n_of(sel)); v++)
      if (r[v] != (v == (1 << n_of(sel)) - 1)) e++;
    return (e > errmax_of(sel)) ? errmax_of(sel) : e;
  endfunction
  function automatic int model_first(input int sel, input logic [7:0] r);
    for (int v = 0; v < (1 << n_of(sel)); v++)
      if (r[v] != (v == (1 << n_of(sel)) - 1)) return v;
    return -1;
  endfunction
  function automatic int last_cycle(input int sel);
    return (1 << n_of(sel)) * (s_of(sel) + 1);
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0: start_a = v;
      1: start_b = v;
      default: start_c = v;
    endcase
  endtask

  task automatic capture(input int sel, input int c);
    case (sel)
      0: begin obs_vec[c] = vec_a; obs_busy[c] = busy_a; obs_done[c] = done_a;
               obs_pass = pass_a; obs_err = err_a; obs_fv = fv_a; obs_ff = ff_a; end
      1: begin obs_vec[c] = vec_b; obs_busy[c] = busy_b; obs_done[c] = done_b;
               obs_pass = pass_b; obs_err = err_b; obs_fv = fv_b; obs_ff = ff_b; end
      default: begin obs_vec[c] = vec_c; obs_busy[c] = busy_c; obs_done[c] = done_c;
               obs_pass = pass_c; obs_err = err_c; obs_fv = fv_c; obs_ff = ff_c; end
    endcase
  endtask

  // Start pulse in cycle 0, extra start pulses in cycles flagged by 'pulses'.
  task automatic run(input int sel, input logic [31:0] pulses);
    @(negedge clk);
    set_start(sel, 1'b1);
    for (int c = 1; c <= MAXC; c++) begin
      @(negedge clk);
      set_start(sel, pulses[c]);
      capture(sel, c);
    end
    set_start(sel, 1'b0);
  endtask

  function automatic int first_done;
    for (int c = 1; c <= MAXC; c++) if (obs_done[c] != 0) return c;
    return -1;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({vec_a, busy_a, done_a, pass_a, err_a, fv_a, ff_a} !== '0) begin
      n_fail++; $display("FAIL reset_a: got %h required 0", {vec_a, busy_a, done_a, pass_a, err_a, fv_a, ff_a});
    end
    n_checks++;
    if ({vec_b, busy_b, done_b, pass_b, err_b, fv_b, ff_b} !== '0) begin
      n_fail++; $display("FAIL reset_b: got %h required 0", {vec_b, busy_b, done_b, pass_b, err_b, fv_b, ff_b});
    end
    n_checks++;
    if ({vec_c, busy_c, done_c, pass_c, err_c, fv_c, ff_c} !== '0) begin
      n_fail++; $display("FAIL reset_c: got %h required 0", {vec_c, busy_c, done_c, pass_c, err_c, fv_c, ff_c});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_correct_and;
    resp = 8'h08;
    run(0, 32'h0);
    for (int c = 1; c <= MAXC; c++) begin
      int lc = last_cycle(0);
      int ev = (c <= lc) ? (c - 1) / (s_of(0) + 1) : 3;
      n_checks++;
      if (obs_vec[c] != ev || obs_busy[c] != int'(c <= lc) || obs_done[c] != int'(c > lc)) begin
        n_fail++;
        $display("FAIL and2_trace c=%0d: vec/busy/done got %0d/%0d/%0d required %0d/%0d/%0d",
                 c, obs_vec[c], obs_busy[c], obs_done[c], ev, int'(c <= lc), int'(c > lc));
      end
    end
    n_checks++;
    if (first_done() != 13) begin n_fail++; $display("FAIL and2_done_cycle: got %0d required 13", first_done()); end
    n_checks++;
    if (obs_pass != 1 || obs_err != 0 || obs_fv != 0) begin
      n_fail++; $display("FAIL and2_result: pass/err/fv got %0d/%0d/%0d required 1/0/0", obs_pass, obs_err, obs_fv);
    end
  endtask

  task automatic test_stuck_at_1;
    resp = 8'hFF;
    run(0, 32'h0);
    n_checks++;
    if (obs_err != 3 || obs_ff != 0 || obs_fv != 1 || obs_pass != 0) begin
      n_fail++; $display("FAIL stuck1: err/ff/fv/pass got %0d/%0d/%0d/%0d required 3/0/1/0",
                         obs_err, obs_ff, obs_fv, obs_pass);
    end
  endtask

  task automatic test_restart_from_done;
    resp = 8'h08;
    run(0, 32'h0);
    n_checks++;
    if (obs_done[1] != 0 || obs_busy[1] != 1) begin
      n_fail++; $display("FAIL restart_drop: done/busy got %0d/%0d required 0/1", obs_done[1], obs_busy[1]);
    end
    n_checks++;
    if (obs_err != 0 || obs_fv != 0 || obs_pass != 1) begin
      n_fail++; $display("FAIL restart_result: err/fv/pass got %0d/%0d/%0d required 0/0/1", obs_err, obs_fv, obs_pass);
    end
  endtask

  task automatic test_reset_mid_run;
    resp = 8'hFF;
    @(negedge clk);
    start_a = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    n_checks++;
    if (err_a !== 8'd1 || busy_a !== 1'b1) begin
      n_fail++; $display("FAIL midrun_pre: err/busy got %0d/%0d required 1/1", err_a, busy_a);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({vec_a, busy_a, done_a, pass_a, err_a, fv_a, ff_a} !== '0) begin
      n_fail++; $display("FAIL midrun_reset: got %h required 0", {vec_a, busy_a, done_a, pass_a, err_a, fv_a, ff_a});
    end
    rst_n = 1'b1;
    resp = 8'h08;
    run(0, 32'h0);
    n_checks++;
    if (first_done() != 13 || obs_pass != 1 || obs_err != 0) begin
      n_fail++; $display("FAIL midrun_rerun: done_cycle/pass/err got %0d/%0d/%0d required 13/1/0",
                         first_done(), obs_pass, obs_err);
    end
  endtask

  task automatic test_start_while_busy;
    resp = 8'h08;
    run(0, (32'h1 << 3) | (32'h1 << 7));
    n_checks++;
    if (first_done() != 13 || obs_pass != 1) begin
      n_fail++; $display("FAIL busy_start: done_cycle/pass got %0d/%0d required 13/1", first_done(), obs_pass);
    end
    n_checks++;
    if (obs_vec[8] != 2 || obs_vec[12] != 3) begin
      n_fail++; $display("FAIL busy_start_vec: vec@8/vec@12 got %0d/%0d required 2/3", obs_vec[8], obs_vec[12]);
    end
  endtask

  task automatic test_and3_fault;
    resp = 8'h80 ^ 8'h20;
    run(1, 32'h0);
    n_checks++;
    if (first_done() != 17) begin n_fail++; $display("FAIL and3_done_cycle: got %0d required 17", first_done()); end
    n_checks++;
    if (obs_err != 1 || obs_ff != 5 || obs_fv != 1 || obs_pass != 0) begin
      n_fail++; $display("FAIL and3_fault: err/ff/fv/pass got %0d/%0d/%0d/%0d required 1/5/1/0",
                         obs_err, obs_ff, obs_fv, obs_pass);
    end
  endtask

  task automatic test_saturation;
    resp = 8'h07;
    run(2, 32'h0);
    n_checks++;
    if (obs_err != 3 || obs_ff != 0 || obs_pass != 0 || first_done() != 9) begin
      n_fail++; $display("FAIL saturate: err/ff/pass/done_cycle got %0d/%0d/%0d/%0d required 3/0/0/9",
                         obs_err, obs_ff, obs_pass, first_done());
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 8; it++) begin
      int sel = $urandom_range(2, 0);
      int lc = last_cycle(sel);
      logic [31:0] window = ((32'h1 << (lc + 1)) - 1) & ~32'h1;
      logic [31:0] pulses = $urandom & window;
      int ef, ee;
      resp = 8'($urandom);
      run(sel, pulses);
      ee = model_errs(sel, resp);
      ef = model_first(sel, resp);
      for (int c = 1; c <= MAXC; c++) begin
        int ev = (c <= lc) ? (c - 1) / (s_of(sel) + 1) : (1 << n_of(sel)) - 1;
        n_checks++;
        if (obs_vec[c] != ev || obs_done[c] != int'(c > lc)) begin
          n_fail++; $display("FAIL rand_trace it=%0d sel=%0d c=%0d: vec/done got %0d/%0d required %0d/%0d",
                             it, sel, c, obs_vec[c], obs_done[c], ev, int'(c > lc));
        end
      end
      n_checks++;
      if (obs_err != ee || obs_fv != int'(ef >= 0) || (ef >= 0 && obs_ff != ef) || obs_pass != int'(ee == 0)) begin
        n_fail++; $display("FAIL rand_result it=%0d sel=%0d resp=%h: err/fv/ff/pass got %0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d",
                           it, sel, resp, obs_err, obs_fv, obs_ff, obs_pass, ee, int'(ef >= 0), ef, int'(ee == 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_correct_and();
    test_stuck_at_1();
    test_restart_from_done();
    test_reset_mid_run();
    test_start_while_busy();
    test_and3_fault();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
